// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//
// MEM/WB pipeline register with the writeback-data selector folded in.
// At the end of MEM it captures the ALU result, the raw load word and the
// old PC. It picks the register-file write data and presents it as a fully
// registered write port.
//
// Output qualification: wb_valid marks a real instruction in WB. The
// register-file write happens only when wb_reg_write is 1. wb_rd and
// wb_data are captured every non-stalled, non-flushed cycle, so they are
// only meaningful when wb_reg_write is 1. There is no ready: the stage
// never back-pressures, and stall_i is the only hold mechanism.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (beats flush, beats stall)
//   stall_i        hold every output register
//   flush_i        insert a bubble (all outputs to 0), beats stall
//   in_valid       MEM-stage instruction valid
//   in_alu_data    ALU result / effective address (low 2 bits = byte offset)
//   in_mem_data    raw aligned word from data memory
//   in_old_pc      PC of the instruction
//   in_wb_sel      00 ALU, 01 MEM, 10 PC+LINK_OFFSET, 11 illegal
//   in_ld_mode     000 word, 001 byte s, 010 byte u, 011 half s, 100 half u
//   in_reg_write   instruction writes the register file
//   in_rd          destination register
//   wb_valid       registered valid
//   wb_reg_write   register-file write enable
//   wb_rd          destination register
//   wb_data        writeback data
//   wb_illegal_sel pulse: the captured valid instruction had wb_sel=11
// ---------------------------------------------------------------------------
module wb_select_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int LINK_OFFSET = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_alu_data,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_old_pc,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_ld_mode,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_illegal_sel
);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    localparam logic [2:0] LD_WORD = 3'b000;
    localparam logic [2:0] LD_BS   = 3'b001;
    localparam logic [2:0] LD_BU   = 3'b010;
    localparam logic [2:0] LD_HS   = 3'b011;
    localparam logic [2:0] LD_HU   = 3'b100;

    localparam logic [DATA_W-1:0] LINK_INC = DATA_W'(LINK_OFFSET);

    logic                  valid_q,     valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] rd_q,        rd_d;
    logic [DATA_W-1:0]     data_q,      data_d;
    logic                  illegal_q,   illegal_d;

    logic [1:0]            ld_off;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_W-1:0]     ld_data;

    // Little-endian lane pick from the aligned memory word.
    assign ld_off = in_alu_data[1:0];

    always_comb begin
        ld_byte = 8'h00;
        case (ld_off)
            2'd0:    ld_byte = in_mem_data[7:0];
            2'd1:    ld_byte = in_mem_data[15:8];
            2'd2:    ld_byte = in_mem_data[23:16];
            default: ld_byte = in_mem_data[31:24];
        endcase
    end

    // Misaligned halfwords (off[0]=1) silently use the enclosing half.
    assign ld_half = ld_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];

    always_comb begin
        ld_data = in_mem_data;
        case (in_ld_mode)
            LD_BS:   ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            LD_HS:   ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            LD_WORD: ld_data = in_mem_data;
            default: ld_data = in_mem_data;
        endcase
    end

    always_comb begin
        valid_d     = in_valid;
        rd_d        = in_rd;
        illegal_d   = 1'b0;
        data_d      = in_alu_data;
        case (in_wb_sel)
            SEL_ALU: data_d = in_alu_data;
            SEL_MEM: data_d = ld_data;
            SEL_PC:  data_d = in_old_pc + LINK_INC;
            SEL_ILL: begin
                data_d    = '0;
                illegal_d = in_valid;
            end
            default: data_d = '0;
        endcase
        // Writes to $zero are dropped, but rd/data are still captured.
        reg_write_d = in_valid && in_reg_write && (in_rd != '0) && (in_wb_sel != SEL_ILL);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            illegal_q   <= 1'b0;
        end else if (!stall_i) begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            illegal_q   <= illegal_d;
        end
    end

    assign wb_valid       = valid_q;
    assign wb_reg_write   = reg_write_q;
    assign wb_rd          = rd_q;
    assign wb_data        = data_q;
    assign wb_illegal_sel = illegal_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_select_stage
//
// Directed bench for wb_select_stage. Each driven cycle pushes the
// hand-computed output vector that the following edge must produce onto
// exp_q. A separate monitor compares the DUT against the head of the queue
// on every falling edge.
// Vector layout: {valid, reg_write, illegal, rd[4:0], data[31:0]}.
// ---------------------------------------------------------------------------
module tb_wb_select_stage;

    localparam int W = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        in_valid;
    logic [31:0] in_alu_data;
    logic [31:0] in_mem_data;
    logic [31:0] in_old_pc;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_ld_mode;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal_sel;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] last_exp;
    int           n_checks = 0;
    int           n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    wb_select_stage #(
        .DATA_W(32),
        .REG_ADDR_W(5),
        .LINK_OFFSET(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .in_valid       (in_valid),
        .in_alu_data    (in_alu_data),
        .in_mem_data    (in_mem_data),
        .in_old_pc      (in_old_pc),
        .in_wb_sel      (in_wb_sel),
        .in_ld_mode     (in_ld_mode),
        .in_reg_write   (in_reg_write),
        .in_rd          (in_rd),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_illegal_sel (wb_illegal_sel)
    );

    function automatic logic [W-1:0] mk(input logic v, input logic rw, input logic ill,
                                        input logic [4:0] rd, input logic [31:0] d);
        return {v, rw, ill, rd, d};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] ld,
                         input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc);
        in_valid     = v;
        in_wb_sel    = sel;
        in_ld_mode   = ld;
        in_reg_write = rw;
        in_rd        = rd;
        in_alu_data  = alu;
        in_mem_data  = mem;
        in_old_pc    = pc;
    endtask

    // Let one edge happen and record what it must produce.
    task automatic tick(input string name, input logic [W-1:0] e);
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(name);
        last_exp = e;
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] got;
            string        nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {wb_valid, wb_reg_write, wb_illegal_sel, wb_rd, wb_data};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL %s: got v=%0b rw=%0b ill=%0b rd=%0d data=%08h, want v=%0b rw=%0b ill=%0b rd=%0d data=%08h",
                         nm, got[39], got[38], got[37], got[36:32], got[31:0],
                         e[39], e[38], e[37], e[36:32], e[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ldw;
        ldw = 32'h80FF7F01;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(1, 2'b00, 3'b000, 1, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick("reset0", mk(0, 0, 0, 5'd0, 32'h0));
        tick("reset1", mk(0, 0, 0, 5'd0, 32'h0));
        rst = 1'b0;

        // Three ALU writes, then reset together with stall.
        drive(1, 2'b00, 3'b000, 1, 5'd1, 32'h100, 32'h0, 32'h0);
        tick("alu_w1", mk(1, 1, 0, 5'd1, 32'h100));
        drive(1, 2'b00, 3'b000, 1, 5'd2, 32'h200, 32'h0, 32'h0);
        tick("alu_w2", mk(1, 1, 0, 5'd2, 32'h200));
        drive(1, 2'b00, 3'b000, 1, 5'd3, 32'h300, 32'h0, 32'h0);
        tick("alu_w3", mk(1, 1, 0, 5'd3, 32'h300));
        rst = 1'b1; stall_i = 1'b1;
        drive(1, 2'b00, 3'b000, 1, 5'd9, 32'h999, 32'h0, 32'h0);
        tick("rst_over_stall", mk(0, 0, 0, 5'd0, 32'h0));
        rst = 1'b0; stall_i = 1'b0;
        drive(1, 2'b00, 3'b000, 1, 5'd4, 32'h400, 32'h0, 32'h0);
        tick("after_rst", mk(1, 1, 0, 5'd4, 32'h400));

        // Select paths.
        drive(1, 2'b00, 3'b000, 1, 5'd8, 32'h12345678, 32'h0, 32'h0);
        tick("sel_alu", mk(1, 1, 0, 5'd8, 32'h12345678));
        drive(1, 2'b10, 3'b000, 1, 5'd31, 32'h0, 32'h0, 32'h00400010);
        tick("sel_link", mk(1, 1, 0, 5'd31, 32'h00400014));
        drive(1, 2'b10, 3'b000, 1, 5'd1, 32'h0, 32'h0, 32'hFFFFFFFC);
        tick("link_wrap", mk(1, 1, 0, 5'd1, 32'h00000000));

        // Load extraction from 0x80FF7F01.
        drive(1, 2'b01, 3'b001, 1, 5'd9, 32'h1001, ldw, 32'h0);
        tick("lb_off1", mk(1, 1, 0, 5'd9, 32'h0000007F));
        drive(1, 2'b01, 3'b001, 1, 5'd9, 32'h1003, ldw, 32'h0);
        tick("lb_off3", mk(1, 1, 0, 5'd9, 32'hFFFFFF80));
        drive(1, 2'b01, 3'b010, 1, 5'd9, 32'h1002, ldw, 32'h0);
        tick("lbu_off2", mk(1, 1, 0, 5'd9, 32'h000000FF));
        drive(1, 2'b01, 3'b011, 1, 5'd9, 32'h1002, ldw, 32'h0);
        tick("lh_off2", mk(1, 1, 0, 5'd9, 32'hFFFF80FF));
        drive(1, 2'b01, 3'b100, 1, 5'd9, 32'h1000, ldw, 32'h0);
        tick("lhu_off0", mk(1, 1, 0, 5'd9, 32'h00007F01));
        drive(1, 2'b01, 3'b000, 1, 5'd9, 32'h1000, ldw, 32'h0);
        tick("lw", mk(1, 1, 0, 5'd9, 32'h80FF7F01));
        drive(1, 2'b01, 3'b011, 1, 5'd9, 32'h1003, ldw, 32'h0);
        tick("lh_off3", mk(1, 1, 0, 5'd9, 32'hFFFF80FF));
        drive(1, 2'b01, 3'b111, 1, 5'd9, 32'h1001, ldw, 32'h0);
        tick("ld_mode_other", mk(1, 1, 0, 5'd9, 32'h80FF7F01));

        // Stall / flush.
        drive(1, 2'b00, 3'b000, 1, 5'd3, 32'h11, 32'h0, 32'h0);
        tick("cap_a", mk(1, 1, 0, 5'd3, 32'h11));
        stall_i = 1'b1;
        drive(1, 2'b00, 3'b000, 1, 5'd4, 32'h22, 32'h0, 32'h0);
        tick("stall_hold1", last_exp);
        tick("stall_hold2", last_exp);
        flush_i = 1'b1;
        tick("flush_over_stall", mk(0, 0, 0, 5'd0, 32'h0));
        stall_i = 1'b0; flush_i = 1'b0;
        tick("cap_b", mk(1, 1, 0, 5'd4, 32'h22));

        // $zero, illegal select, invalid input.
        drive(1, 2'b00, 3'b000, 1, 5'd0, 32'h55, 32'h0, 32'h0);
        tick("rd_zero", mk(1, 0, 0, 5'd0, 32'h55));
        drive(1, 2'b11, 3'b000, 1, 5'd5, 32'h77, 32'h0, 32'h0);
        tick("illegal_sel", mk(1, 0, 1, 5'd5, 32'h0));
        stall_i = 1'b1;
        tick("illegal_stall_hold", last_exp);
        stall_i = 1'b0;
        drive(1, 2'b00, 3'b000, 1, 5'd6, 32'h66, 32'h0, 32'h0);
        tick("illegal_one_cycle", mk(1, 1, 0, 5'd6, 32'h66));
        drive(0, 2'b11, 3'b000, 1, 5'd5, 32'h77, 32'h0, 32'h0);
        tick("illegal_invalid", mk(0, 0, 0, 5'd5, 32'h0));
        drive(0, 2'b00, 3'b000, 1, 5'd6, 32'h66, 32'h0, 32'h0);
        tick("invalid_capture", mk(0, 0, 0, 5'd6, 32'h66));

        // Back-to-back, rotating sel 00/01/10.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  s;
            logic [31:0] d;
            s = 2'(i % 3);
            case (s)
                2'b00:   d = 32'h1000 + 32'(i);
                2'b01:   d = 32'hA000_0000 + 32'(i);
                default: d = 32'h2000 + 32'(4 * i) + 32'd4;
            endcase
            drive(1, s, 3'b000, 1, 5'(10 + i), 32'h1000 + 32'(i),
                  32'hA000_0000 + 32'(i), 32'h2000 + 32'(4 * i));
            tick($sformatf("b2b_%0d", i), mk(1, 1, 0, 5'(10 + i), d));
        end
        drive(0, 2'b00, 3'b000, 0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
